// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded bursts and full stalls.
// Optional saturating write-error counter enabled by defining FIFO_WR_ERR_CNT_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] data_i,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic [WIDTH-1:0]         fifo_wdata_o,
   output logic                     fifo_wr_en_o,
   input  logic                     fifo_full_i,
   input  logic                     fifo_wr_error_i,
   output logic                     busy_o,
   output logic [7:0]               err_cnt_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic               found;
   logic [PTR_W-1:0]   sel_idx;
   logic [PTR_W-1:0]   cand_idx;
   int                 cand;
   logic [PTR_W-1:0]   next_ptr;
   logic               req_g;
   logic               wr_en;
   logic               end_burst;

   // First requester at or above rr_ptr, wrapping back to index 0.
   always_comb begin
      found    = 1'b0;
      sel_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = PTR_W'(cand);
         if (!found && req_i[cand_idx]) begin
            found   = 1'b1;
            sel_idx = cand_idx;
         end
      end
   end

   assign next_ptr = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
   assign req_g    = req_i[gidx_q];
   assign wr_en    = (state_q == BURST) && req_g && !fifo_full_i;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      end_burst  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = BURST;
               grant_d    = NUM_REQ'(1) << sel_idx;
               gidx_d     = sel_idx;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (wr_en) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (!req_g)
               end_burst = 1'b1;
            else if (wr_en && beat_cnt_q == CNT_W'(MAX_BURST - 1))
               end_burst = 1'b1;
            else if (fifo_full_i)
               state_d = STALL;
         end
         STALL: begin
            if (!req_g)
               end_burst = 1'b1;
            else if (!fifo_full_i)
               state_d = BURST;
         end
         default: state_d = IDLE;
      endcase
      if (end_burst) begin
         state_d    = IDLE;
         grant_d    = '0;
         rr_ptr_d   = next_ptr;
         beat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         gidx_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         gidx_q     <= gidx_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign grant_o      = grant_q;
   assign fifo_wr_en_o = wr_en;
   assign ack_o        = wr_en ? grant_q : '0;
   assign busy_o       = (state_q != IDLE);
   assign fifo_wdata_o = (|grant_q) ? data_i[gidx_q*WIDTH +: WIDTH] : '0;

`ifdef FIFO_WR_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (fifo_wr_error_i && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_cnt_q <= '0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt_o = err_cnt_q;
`else
   logic unused_wr_error;
   assign unused_wr_error = fifo_wr_error_i;
   assign err_cnt_o       = '0;
`endif

endmodule
